la_cellbist4: RTL and testbench



---
 rtl/la_cellbist_pkg.sv | 22 ++
 rtl/la_misr16.sv | 30 +++
 rtl/la_cellbist4.sv | 106 ++++++++++
 tb/tb_la_cellbist4.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/la_cellbist_pkg.sv
// Shared types and constants for the la_cellbist family of 4-input cell BIST blocks.
// Vector index v = {c0,b0,a1,a0}; TT_*[v] is the expected cell output for that vector.
package la_cellbist_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [15:0] TT_AOI211 = 16'h0007;
    localparam logic [15:0] TT_OAI211 = 16'h1FFF;
    localparam logic [15:0] TT_AOI22  = 16'h0777;
    localparam logic [15:0] TT_OAI22  = 16'h111F;
    localparam logic [15:0] TT_NAND4  = 16'h7FFF;
    localparam logic [15:0] TT_NOR4   = 16'h0001;

    // x^16+x^15+x^13+x^4+1, implicit x^16 term
    localparam logic [15:0] MISR_POLY = 16'hA011;

endpackage

// File: rtl/la_misr16.sv
// 16-bit serial-input signature register; clear seeds all-ones, shift_en folds din in.
module la_misr16
    import la_cellbist_pkg::*;
(
    input  logic        clk,
    input  logic        nreset,
    input  logic        clear,
    input  logic        shift_en,
    input  logic        din,
    output logic [15:0] sig
);

    logic [15:0] r_sig;
    logic [15:0] w_sig_next;

    assign w_sig_next = {r_sig[14:0], din} ^ (r_sig[15] ? MISR_POLY : 16'h0000);

    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_sig <= 16'h0000;
        end else if (clear) begin
            r_sig <= 16'hFFFF;
        end else if (shift_en) begin
            r_sig <= w_sig_next;
        end
    end

    assign sig = r_sig;

endmodule

// File: rtl/la_cellbist4.sv
// Exhaustive 16-vector BIST driver/checker for a 4-input cell under test.
// Optional MISR signature when LA_CELLBIST4_MISR_EN is defined; otherwise signature is 0.
module la_cellbist4
    import la_cellbist_pkg::*;
#(
    parameter              PROP   = "DEFAULT",
    parameter logic [15:0] TRUTH  = TT_AOI211,
    parameter int          SETTLE = 2
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        start,
    input  logic        z_dut,
    output logic        a0,
    output logic        a1,
    output logic        b0,
    output logic        c0,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [4:0]  fail_count,
    output logic [15:0] fail_vec,
    output logic [15:0] signature
);

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_vec;
    logic [3:0]  r_cnt;
    logic [4:0]  r_fail_count;
    logic [15:0] r_fail_vec;
    logic        w_start_run;
    logic        w_settled;
    logic        w_mismatch;

    // start is only honoured when no run is active
    assign w_start_run = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_settled   = (r_cnt == 4'(SETTLE - 1));
    assign w_mismatch  = (r_state == SAMPLE) && (z_dut != TRUTH[r_vec]);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = DRIVE;
            DRIVE:   if (w_settled) w_next = SAMPLE;
            SAMPLE:  w_next = (r_vec == 4'hF) ? DONE : DRIVE;
            DONE:    if (start) w_next = DRIVE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_vec        <= 4'd0;
            r_cnt        <= 4'd0;
            r_fail_count <= 5'd0;
            r_fail_vec   <= 16'h0000;
        end else if (w_start_run) begin
            r_vec        <= 4'd0;
            r_cnt        <= 4'd0;
            r_fail_count <= 5'd0;
            r_fail_vec   <= 16'h0000;
        end else if (r_state == DRIVE) begin
            r_cnt <= r_cnt + 4'd1;
        end else if (r_state == SAMPLE) begin
            if (w_mismatch) begin
                r_fail_vec[r_vec] <= 1'b1;
                r_fail_count      <= r_fail_count + 5'd1;
            end
            // vec stays at 15 after the last vector so DONE keeps driving 4'hF
            if (r_vec != 4'hF) begin
                r_vec <= r_vec + 4'd1;
                r_cnt <= 4'd0;
            end
        end
    end

    assign {c0, b0, a1, a0} = r_vec;
    assign busy       = (r_state == DRIVE) || (r_state == SAMPLE);
    assign done       = (r_state == DONE);
    assign pass       = done && (r_fail_count == 5'd0);
    assign fail_count = r_fail_count;
    assign fail_vec   = r_fail_vec;

`ifdef LA_CELLBIST4_MISR_EN
    la_misr16 u_misr (
        .clk      (clk),
        .nreset   (nreset),
        .clear    (w_start_run),
        .shift_en (r_state == SAMPLE),
        .din      (z_dut),
        .sig      (signature)
    );
`else
    assign signature = 16'h0000;
`endif

endmodule

// File: tb/tb_la_cellbist4.sv
// Directed bench for la_cellbist4 with a behavioural aoi211 cell and fault modes on z_dut.
module tb_la_cellbist4;

    logic        clk;
    logic        nreset;
    logic        start;
    logic        z_dut;
    logic        a0, a1, b0, c0;
    logic        busy, done, pass;
    logic [4:0]  fail_count;
    logic [15:0] fail_vec;
    logic [15:0] signature;

    int n_cmp;
    int n_bad;
    int mode;     // 0 golden, 1 stuck-at-0, 2 stuck-at-1, 3 golden with vector 9 flipped
    logic [3:0] st_log [0:255];
    logic [4:0] fc_log [0:255];

    la_cellbist4 #(
        .PROP   ("DEFAULT"),
        .TRUTH  (16'h0007),
        .SETTLE (2)
    ) dut (
        .clk        (clk),
        .nreset     (nreset),
        .start      (start),
        .z_dut      (z_dut),
        .a0         (a0),
        .a1         (a1),
        .b0         (b0),
        .c0         (c0),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .fail_count (fail_count),
        .fail_vec   (fail_vec),
        .signature  (signature)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic zval(input int m, input logic [3:0] v);
        logic g;
        g = !((v[0] & v[1]) | v[2] | v[3]);
        case (m)
            1:       zval = 1'b0;
            2:       zval = 1'b1;
            3:       zval = g ^ (v == 4'd9);
            default: zval = g;
        endcase
    endfunction

    always_comb z_dut = zval(mode, {c0, b0, a1, a0});

    function automatic logic [15:0] misr_model(input int m);
        logic [15:0] s;
        logic [15:0] n;
        logic [15:0] p;
        logic        fb;
        p = 16'hA011;
        s = 16'hFFFF;
        for (int v = 0; v < 16; v++) begin
            fb = s[15];
            for (int i = 15; i >= 1; i--) n[i] = s[i-1] ^ (fb & p[i]);
            n[0] = (fb & p[0]) ^ zval(m, 4'(v));
            s = n;
        end
        return s;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic log_cycle(input int c);
        st_log[c] = {c0, b0, a1, a0};
        fc_log[c] = fail_count;
    endtask

    // Start a run and follow it to done (or a cycle bound); optional mid-run start pulse and reset abort.
    task automatic run(input int m, input int pulse_at, input int abort_at, output int cyc);
        int seen;
        mode  = m;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_busy", 32'(busy), 32'd1);
        check("start_done_low", 32'(done), 32'd0);
        check("start_fc_clear", 32'(fail_count), 32'd0);
        check("start_fv_clear", 32'(fail_vec), 32'd0);
        cyc = 0;
        log_cycle(0);
        while (done !== 1'b1 && cyc < 200) begin
            start = (cyc == pulse_at);
            tick();
            cyc++;
            log_cycle(cyc);
            if (cyc == abort_at) begin
                start  = 1'b0;
                nreset = 1'b0;
                tick();
                check("abort_stim", 32'({c0, b0, a1, a0}), 32'd0);
                check("abort_busy", 32'(busy), 32'd0);
                check("abort_done", 32'(done), 32'd0);
                check("abort_fc", 32'(fail_count), 32'd0);
                check("abort_fv", 32'(fail_vec), 32'd0);
                check("abort_sig", 32'(signature), 32'd0);
                nreset = 1'b1;
                seen = 0;
                repeat (60) begin
                    tick();
                    if (done === 1'b1 || busy === 1'b1) seen = 1;
                end
                check("abort_stays_idle", 32'(seen), 32'd0);
                cyc = -1;
                return;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        int cyc;
        int n6;
        int first6;
        logic [15:0] sig_golden;
        n_cmp  = 0;
        n_bad  = 0;
        mode   = 0;
        start  = 1'b0;
        nreset = 1'b0;
        tick();
        tick();
        check("rst_stim", 32'({c0, b0, a1, a0}), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_fc", 32'(fail_count), 32'd0);
        check("rst_fv", 32'(fail_vec), 32'd0);
        check("rst_sig", 32'(signature), 32'd0);
        nreset = 1'b1;
        tick();

        // Golden run plus stimulus-order and latency checks
        run(0, -10, -10, cyc);
        check("gold_latency", 32'(cyc), 32'd48);
        check("gold_pass", 32'(pass), 32'd1);
        check("gold_fc", 32'(fail_count), 32'd0);
        check("gold_fv", 32'(fail_vec), 32'd0);
        check("gold_busy_low", 32'(busy), 32'd0);
        check("done_stim_F", 32'({c0, b0, a1, a0}), 32'hF);
        check("stim_first", 32'(st_log[0]), 32'd0);
        n6 = 0;
        first6 = -1;
        for (int i = 0; i <= 48; i++) begin
            if (st_log[i] == 4'd6) begin
                n6++;
                if (first6 < 0) first6 = i;
            end
        end
        check("vec6_cycles", 32'(n6), 32'd3);
        check("vec6_first", 32'(first6), 32'd18);
        check("vec6_bits", 32'({a0, a1, b0, c0}), 32'b1111);
        check("vec6_pattern", 32'(st_log[19]), 32'b0110);
`ifdef LA_CELLBIST4_MISR_EN
        sig_golden = misr_model(0);
        check("misr_golden", 32'(signature), 32'(sig_golden));
`else
        sig_golden = 16'h0000;
        check("sig_tied_zero", 32'(signature), 32'd0);
`endif
        tick();
        check("done_held", 32'(done), 32'd1);

        // Stuck-at-0: vectors 0..2 expect 1
        run(1, -10, -10, cyc);
        check("sa0_latency", 32'(cyc), 32'd48);
        check("sa0_fc", 32'(fail_count), 32'd3);
        check("sa0_fv", 32'(fail_vec), 32'h0007);
        check("sa0_pass", 32'(pass), 32'd0);
        check("sa0_fc_before_cmp2", 32'(fc_log[8]), 32'd2);
        check("sa0_fc_after_cmp2", 32'(fc_log[9]), 32'd3);

        // Restart from DONE with the golden cell; run() checks results clear on the start edge
        run(0, -10, -10, cyc);
        check("restart_latency", 32'(cyc), 32'd48);
        check("restart_fc", 32'(fail_count), 32'd0);
        check("restart_fv", 32'(fail_vec), 32'd0);
        check("restart_pass", 32'(pass), 32'd1);

        // Stuck-at-1: vectors 3..15 expect 0
        run(2, -10, -10, cyc);
        check("sa1_fc", 32'(fail_count), 32'd13);
        check("sa1_fv", 32'(fail_vec), 32'hFFF8);
        check("sa1_pass", 32'(pass), 32'd0);

        // start pulsed during vector 4 must not disturb the run
        run(0, 12, -10, cyc);
        check("midstart_latency", 32'(cyc), 32'd48);
        check("midstart_pass", 32'(pass), 32'd1);

        // Flipped vector-9 response
        run(3, -10, -10, cyc);
        check("flip9_fc", 32'(fail_count), 32'd1);
        check("flip9_fv", 32'(fail_vec), 32'h0200);
`ifdef LA_CELLBIST4_MISR_EN
        check("misr_flip9", 32'(signature), 32'(misr_model(3)));
        check("misr_flip9_differs", 32'(signature != sig_golden), 32'd1);
`else
        check("sig_tied_zero_flip", 32'(signature), 32'd0);
`endif

        // Reset asserted while vector 5 is on the pins
        run(0, -10, 15, cyc);
        check("abort_return", 32'(cyc), 32'hFFFF_FFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
